// File: rtl/pc_seq_ctrl.sv
`timescale 1ns/1ps
// Program counter sequencer: BOOT/FETCH/DECODE/EXEC/UPDATE/HALT cycle with
// memory-latency tolerance, branch select, halt at instruction boundary.
module pc_seq_ctrl #(
    parameter int             N       = 32,
    parameter int             INC     = 4,
    parameter logic [N-1:0]   RST_VEC = '0,
    parameter int             TMO     = 15
) (
    input  logic         i_clk,
    input  logic         i_rst_,
    input  logic [N-1:0] i_pcData,
    input  logic         i_memReady,
    input  logic         i_branchTaken,
    input  logic [N-1:0] i_branchTarget,
    input  logic         i_halt,
    input  logic         i_resume,
    output logic [N-1:0] o_pcData,
    output logic         o_pcWriteEn,
    output logic         o_pcReadEn,
    output logic         o_memReadEn,
    output logic         o_irLoad,
    output logic         o_execEn,
    output logic [2:0]   o_state,
    output logic         o_halted,
    output logic         o_fault
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_BOOT   = 3'd1,
        S_FETCH  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_UPDATE = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [7:0]   TMO_C = 8'(TMO);
    localparam logic [N-1:0] INC_C = N'(INC);

    state_t       r_state;
    state_t       w_next;
    logic [N-1:0] r_pcCap;
    logic         r_brTaken;
    logic [N-1:0] r_brTarget;
    logic         r_haltReq;
    logic [7:0]   r_waitCnt;
    logic         r_fault;
    logic [N-1:0] w_seqPc;
    logic         w_tmo;

    assign w_seqPc = r_pcCap + INC_C;
    assign w_tmo   = (r_waitCnt >= TMO_C);

    always_ff @(posedge i_clk or negedge i_rst_) begin
        if (!i_rst_) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_pcData    = '0;
        o_pcWriteEn = 1'b0;
        o_pcReadEn  = 1'b0;
        o_memReadEn = 1'b0;
        o_irLoad    = 1'b0;
        o_execEn    = 1'b0;
        o_halted    = 1'b0;
        case (r_state)
            S_RST: begin
                w_next = S_BOOT;
            end
            S_BOOT: begin
                o_pcWriteEn = 1'b1;
                o_pcData    = RST_VEC;
                w_next      = S_FETCH;
            end
            S_FETCH: begin
                o_pcReadEn  = 1'b1;
                o_memReadEn = 1'b1;
                if (i_memReady) begin
                    o_irLoad = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_tmo) begin
                    w_next = S_HALT;
                end
            end
            S_DECODE: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                o_execEn = 1'b1;
                w_next   = S_UPDATE;
            end
            S_UPDATE: begin
                o_pcWriteEn = 1'b1;
                o_pcData    = r_brTaken ? r_brTarget : w_seqPc;
                w_next      = (r_haltReq || i_halt) ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                o_halted = 1'b1;
                if (i_resume) begin
                    w_next = S_FETCH;
                end
            end
            default: begin
                w_next = S_RST;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_) begin
        if (!i_rst_) begin
            r_pcCap    <= '0;
            r_brTaken  <= 1'b0;
            r_brTarget <= '0;
            r_haltReq  <= 1'b0;
            r_waitCnt  <= '0;
            r_fault    <= 1'b0;
        end else begin
            if (r_state == S_FETCH) begin
                if (i_memReady) begin
                    r_pcCap   <= i_pcData;
                    r_waitCnt <= '0;
                end else if (w_tmo) begin
                    r_fault   <= 1'b1;
                    r_waitCnt <= '0;
                end else begin
                    r_waitCnt <= r_waitCnt + 8'd1;
                end
            end
            if (r_state == S_EXEC) begin
                r_brTaken  <= i_branchTaken;
                r_brTarget <= i_branchTarget;
            end
            // Halt is latched mid-instruction and honoured at UPDATE
            if (w_next == S_HALT && r_state != S_HALT) begin
                r_haltReq <= 1'b0;
            end else if (i_halt && r_state != S_RST &&
                         r_state != S_BOOT && r_state != S_HALT) begin
                r_haltReq <= 1'b1;
            end
            if (r_state == S_HALT && i_resume) begin
                r_fault <= 1'b0;
            end
        end
    end

    assign o_state = r_state;
    assign o_fault = r_fault;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for pc_seq_ctrl: expected PC writes queued, checked on write.
module tb_pc_seq_ctrl;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] pcIn;
    logic         memReady;
    logic         brTaken;
    logic [N-1:0] brTarget;
    logic         halt;
    logic         resume;
    logic [N-1:0] pcOut;
    logic         pcWe;
    logic         pcRe;
    logic         memRe;
    logic         irLoad;
    logic         execEn;
    logic [2:0]   state;
    logic         halted;
    logic         fault;

    logic [N-1:0] pc_m = '0;
    logic [N-1:0] sb[$];
    logic [N-1:0] sb_e;
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           t0, t1;

    pc_seq_ctrl #(.N(N), .INC(4), .RST_VEC('0), .TMO(15)) dut (
        .i_clk          (clk),
        .i_rst_         (rst_n),
        .i_pcData       (pcIn),
        .i_memReady     (memReady),
        .i_branchTaken  (brTaken),
        .i_branchTarget (brTarget),
        .i_halt         (halt),
        .i_resume       (resume),
        .o_pcData       (pcOut),
        .o_pcWriteEn    (pcWe),
        .o_pcReadEn     (pcRe),
        .o_memReadEn    (memRe),
        .o_irLoad       (irLoad),
        .o_execEn       (execEn),
        .o_state        (state),
        .o_halted       (halted),
        .o_fault        (fault)
    );

    always #5 clk = ~clk;

    // External PC register the sequencer drives and reads back
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pcWe) pc_m <= pcOut;
    end
    assign pcIn = pc_m;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {pcOut, pcWe, pcRe, memRe, irLoad, execEn,
                  state, halted, fault}, 64'd0);
    endtask

    task automatic wait_state(input logic [2:0] s);
        bit hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            if (state == s) hit = 1'b1;
        end
        if (!hit) chk("st_tmo", state, s);
    endtask

    task automatic wait_wr(output int t);
        bit hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            if (pcWe) hit = 1'b1;
        end
        if (!hit) chk("wr_tmo", pcWe, 1);
        t = cyc;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("excl", pcWe & pcRe, 0);
            if (pcWe) begin
                if (sb.size() == 0) begin
                    chk("sb_unexp", 64'(sb.size()), 1);
                end else begin
                    sb_e = sb.pop_front();
                    chk("pc_wr", pcOut, sb_e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; memReady = 1'b1; brTaken = 1'b0;
        brTarget = '0; halt = 1'b0; resume = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("rst_out");

        // sequential run
        sb.push_back(32'd0); sb.push_back(32'd4);
        sb.push_back(32'd8); sb.push_back(32'd12);
        rst_n = 1'b1;
        wait_wr(t0);
        wait_wr(t1); chk("gap1", t1 - t0, 4); t0 = t1;
        wait_wr(t1); chk("gap2", t1 - t0, 4); t0 = t1;
        wait_wr(t1); chk("gap3", t1 - t0, 4);

        // three wait cycles in FETCH
        memReady = 1'b0; sb.push_back(32'd16);
        @(negedge clk); chk("f1_st", state, 2); chk("f1_ir", irLoad, 0);
        @(negedge clk); chk("f2_ir", irLoad, 0);
        @(negedge clk); chk("f3_ir", irLoad, 0);
        @(negedge clk); chk("f4_st", state, 2);
        memReady = 1'b1; #1 chk("f4_ir", irLoad, 1);
        @(negedge clk); chk("dec_st", state, 3);
        wait_wr(t1);

        // branch taken
        sb.push_back(32'h100); sb.push_back(32'h104);
        wait_state(3'd4); brTaken = 1'b1; brTarget = 32'h100;
        wait_wr(t1); brTaken = 1'b0; brTarget = '0;
        wait_wr(t1);

        // wrap at top of address space
        sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0);
        wait_state(3'd4); brTaken = 1'b1; brTarget = 32'hFFFF_FFFC;
        wait_wr(t1); brTaken = 1'b0; brTarget = '0;
        wait_wr(t1);

        // halt in DECODE, instruction completes, then resume
        wait_state(3'd3); halt = 1'b1; sb.push_back(32'd4);
        @(negedge clk); halt = 1'b0;
        wait_wr(t1);
        @(negedge clk); chk("h_st", state, 6); chk("h_flag", halted, 1);
        @(negedge clk); chk("h_hold", state, 6);
        resume = 1'b1;
        @(negedge clk); resume = 1'b0;
        chk("r_st", state, 2); chk("r_flag", halted, 0);
        sb.push_back(32'd8);
        wait_wr(t1);

        // halt in FETCH, then halt+resume together: resume wins
        wait_state(3'd2); halt = 1'b1; sb.push_back(32'd12);
        @(negedge clk); halt = 1'b0;
        wait_wr(t1);
        @(negedge clk); chk("h2_st", state, 6);
        halt = 1'b1; resume = 1'b1;
        @(negedge clk); halt = 1'b0; resume = 1'b0;
        chk("rw_st", state, 2);
        sb.push_back(32'd16);
        wait_wr(t1);
        @(negedge clk); chk("no_halt", state, 2);

        // ready arrives exactly when the count reaches TMO
        memReady = 1'b0;
        repeat (15) @(negedge clk);
        chk("b16_st", state, 2);
        memReady = 1'b1;
        @(negedge clk); chk("b_dec", state, 3); chk("b_flt", fault, 0);
        sb.push_back(32'd20);
        wait_wr(t1);

        // fetch timeout
        memReady = 1'b0;
        repeat (16) @(negedge clk);
        chk("t16_st", state, 2); chk("t16_flt", fault, 0);
        @(negedge clk);
        chk("t_st", state, 6); chk("t_flt", fault, 1); chk("t_hlt", halted, 1);
        resume = 1'b1; memReady = 1'b1;
        @(negedge clk); resume = 1'b0;
        chk("tr_st", state, 2); chk("tr_flt", fault, 0);
        sb.push_back(32'd24);
        wait_wr(t1);

        // reset mid-EXEC abandons the write, BOOT reloads
        wait_state(3'd4);
        rst_n = 1'b0;
        #1 chk_zero("rst_exec");
        @(negedge clk); rst_n = 1'b1;
        sb.push_back(32'd0); sb.push_back(32'd4);
        wait_wr(t1);
        wait_wr(t1);
        @(negedge clk); chk("sb_left", 64'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
Instruction-cycle sequencer for the program counter register of the simple processor. It drives the PC's write enable, read enable and write data, and handshakes with instruction memory. It computes the next PC: sequential increment or branch target. It replaces the free-running fixed-period PC write counter with a state machine that tolerates variable memory latency, branches, halt/resume and fetch timeouts.

Parameters:
N, 32, PC/address width in bits
INC, 4, byte increment per sequential instruction
RST_VEC, 0, PC value loaded after reset
TMO, 15, max FETCH wait cycles before fault (1..255)

Ports:
i_clk  input  1  clock, rising edge
i_rst_  input  1  asynchronous active-low reset
i_pcData  input  N  PC value read back from the PC bus (valid while o_pcReadEn=1)
i_memReady  input  1  instruction memory data valid
i_branchTaken  input  1  execute stage branch decision
i_branchTarget  input  N  branch destination
i_halt  input  1  halt request
i_resume  input  1  resume from HALT
o_pcData  output  N  data to PC i_data
o_pcWriteEn  output  1  PC write enable
o_pcReadEn  output  1  PC read enable (tri-state output enable)
o_memReadEn  output  1  instruction memory read strobe
o_irLoad  output  1  instruction register load strobe
o_execEn  output  1  execute stage enable
o_state  output  3  current state encoding
o_halted  output  1  in HALT
o_fault  output  1  fetch timeout occurred (sticky)

Behaviour:
- Reset: i_rst_=0 forces state RST asynchronously. It clears pcCap, brTaken, brTarget, haltReq, waitCnt and o_fault. In RST all outputs are 0, o_pcData=0 and o_state=0.
- State encodings: RST=0, BOOT=1, FETCH=2, DECODE=3, EXEC=4, UPDATE=5, HALT=6. Encoding 7 is illegal and goes to RST on the next edge.
- Outputs decode combinationally from state. The only exception is o_irLoad = (state==FETCH) & i_memReady.
- RST -> BOOT on the first clock edge after reset release.
- BOOT: o_pcWriteEn=1, o_pcData=RST_VEC. Next state is FETCH.
- FETCH: o_pcReadEn=1, o_memReadEn=1.
  - If i_memReady=1: o_irLoad=1, pcCap <= i_pcData, waitCnt <= 0, next state DECODE.
  - Otherwise waitCnt increments. When waitCnt reaches TMO with i_memReady still 0: o_fault <= 1, next state HALT.
  - Ready on the same edge as the count reaching TMO counts as success.
- DECODE: one cycle, all strobes 0, next state EXEC.
- EXEC: o_execEn=1 for exactly one cycle. Registers brTaken <= i_branchTaken and brTarget <= i_branchTarget. Next state UPDATE.
- UPDATE: o_pcWriteEn=1.
  - o_pcData = brTaken ? brTarget : pcCap+INC, truncated to N bits (wraps modulo 2^N).
  - Next state is HALT if haltReq is set or i_halt=1 this cycle; otherwise FETCH. haltReq clears on entering HALT.
- haltReq: set by i_halt=1 in any state other than RST, BOOT or HALT. A halt is therefore honoured only at an instruction boundary, and the current instruction always completes.
- HALT: o_halted=1, all other strobes 0.
  - i_resume=1 clears o_fault and goes to FETCH. The PC is unchanged and the fetch restarts at the stored PC.
  - i_halt together with i_resume in HALT: resume wins.
  - i_resume outside HALT is ignored.
- Minimum cycles per instruction is 4 (FETCH, DECODE, EXEC, UPDATE). Each extra i_memReady=0 cycle adds one.
- At most one of o_pcWriteEn and o_pcReadEn is high in any cycle.
- Reset mid-instruction: an in-flight UPDATE write is abandoned. The PC is reloaded by BOOT after release.

Test Plan:
- Reset release, i_memReady tied 1, no branches: BOOT writes 0. Then o_pcWriteEn pulses every 4 cycles with o_pcData 4, 8, 12 (i_pcData echoes the PC model).
- i_memReady held low 3 cycles in FETCH: FETCH lasts 4 cycles, o_irLoad pulses once in cycle 4, and the next UPDATE writes pcCap+4.
- EXEC with i_branchTaken=1 and target 0x100: the UPDATE cycle drives o_pcData=0x100. The next fetch captures 0x100, and the following UPDATE writes 0x104.
- pcCap=0xFFFFFFFC with no branch: UPDATE writes 0x00000000.
- i_halt pulsed during DECODE: UPDATE still writes the next PC, then HALT with o_halted=1. A later i_resume pulse returns to FETCH with the PC unchanged.
- i_memReady stuck 0 for TMO=15: o_fault=1 and o_state=6. i_resume clears o_fault and re-enters FETCH. Asserting i_rst_=0 mid-EXEC forces all outputs to 0 immediately.
